// File: rtl/pixel_scaler.sv
// Integer image scaler: streams a source frame out of a synchronous ROM and writes a
// replicated, decimated or block-averaged copy into the frame buffer in raster order.
module pixel_scaler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IN_W      = 160,
    parameter int unsigned IN_H      = 120,
    parameter int unsigned SHIFT     = 1,
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned RD_ADDR_W = 15,
    parameter int unsigned WR_ADDR_W = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic                 rd_en,
    output logic [RD_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 wr_en,
    output logic [WR_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned ACC_W = DATA_W + 2 * SHIFT;
    localparam int unsigned CNT_W = $clog2(((IN_W > IN_H) ? IN_W : IN_H) << SHIFT) + 1;
    localparam int unsigned ADR_W = RD_ADDR_W;

    localparam logic [CNT_W-1:0] OW_UP = CNT_W'((IN_W << SHIFT) - 1);
    localparam logic [CNT_W-1:0] OH_UP = CNT_W'((IN_H << SHIFT) - 1);
    localparam logic [CNT_W-1:0] OW_DN = CNT_W'((IN_W >> SHIFT) - 1);
    localparam logic [CNT_W-1:0] OH_DN = CNT_W'((IN_H >> SHIFT) - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state_q;
    logic                 avg_q, down_q, last_q;
    logic [CNT_W-1:0]     ox_q, oy_q, ox_d, oy_d;
    logic [SHIFT-1:0]     di_q, dj_q, di_d, dj_d;
    logic [ROM_LAT:0]     tv_q, tf_q, tl_q;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [WR_ADDR_W-1:0] wr_cnt_q;
    logic                 rd_en_q, wr_en_q, busy_q, done_q;
    logic [RD_ADDR_W-1:0] rd_addr_q;
    logic [WR_ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;

    logic             avg_c, down_c, issue_c, pipe_empty_c;
    logic             sub_first_c, sub_last_c, ox_last_c, oy_last_c;
    logic [ADR_W-1:0] row_c, col_c, addr_c;

    // The first read is issued on the start edge, before mode is latched
    always_comb begin
        avg_c  = avg_q;
        down_c = down_q;
        if (state_q == S_IDLE) begin
            avg_c  = (mode == 2'd2);
            down_c = (mode == 2'd1) || (mode == 2'd2);
        end
    end

    always_comb begin
        issue_c      = ((state_q == S_IDLE) && start) || ((state_q == S_RUN) && !last_q);
        pipe_empty_c = ~|tv_q;
        sub_first_c  = !avg_c || ((di_q == '0) && (dj_q == '0));
        sub_last_c   = !avg_c || ((&di_q) && (&dj_q));
        ox_last_c    = (ox_q == (down_c ? OW_DN : OW_UP));
        oy_last_c    = (oy_q == (down_c ? OH_DN : OH_UP));
    end

    // Source address of the read about to be issued
    always_comb begin
        if (down_c) begin
            row_c = (ADR_W'(oy_q) << SHIFT) + ADR_W'(di_q);
            col_c = (ADR_W'(ox_q) << SHIFT) + ADR_W'(dj_q);
        end else begin
            row_c = ADR_W'(oy_q) >> SHIFT;
            col_c = ADR_W'(ox_q) >> SHIFT;
        end
        addr_c = row_c * ADR_W'(IN_W) + col_c;
    end

    // Walk dj, di, ox, oy; wraps back to zero after the final read of the frame
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        di_d = di_q;
        dj_d = dj_q;
        if (!sub_last_c) begin
            dj_d = dj_q + SHIFT'(1);
            if (&dj_q) begin
                di_d = di_q + SHIFT'(1);
            end
        end else begin
            di_d = '0;
            dj_d = '0;
            if (ox_last_c) begin
                ox_d = '0;
                oy_d = oy_last_c ? '0 : oy_q + CNT_W'(1);
            end else begin
                ox_d = ox_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        acc_d     = (tf_q[ROM_LAT] ? ACC_W'(0) : acc_q) + ACC_W'(rd_data);
        wr_data_d = avg_q ? DATA_W'(acc_d >> (2 * SHIFT)) : rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            avg_q     <= 1'b0;
            down_q    <= 1'b0;
            last_q    <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            di_q      <= '0;
            dj_q      <= '0;
            tv_q      <= '0;
            tf_q      <= '0;
            tl_q      <= '0;
            acc_q     <= '0;
            wr_cnt_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Tags ride alongside each read so the data can be matched ROM_LAT cycles later
            tv_q    <= {tv_q[ROM_LAT-1:0], issue_c};
            tf_q    <= {tf_q[ROM_LAT-1:0], sub_first_c};
            tl_q    <= {tl_q[ROM_LAT-1:0], sub_last_c};
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;

            if (tv_q[ROM_LAT]) begin
                acc_q <= acc_d;
                if (tl_q[ROM_LAT]) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= wr_cnt_q;
                    wr_data_q <= wr_data_d;
                    wr_cnt_q  <= wr_cnt_q + WR_ADDR_W'(1);
                end
            end

            rd_en_q <= issue_c;
            if (issue_c) begin
                rd_addr_q <= addr_c;
                ox_q      <= ox_d;
                oy_q      <= oy_d;
                di_q      <= di_d;
                dj_q      <= dj_d;
                last_q    <= sub_last_c && ox_last_c && oy_last_c;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        avg_q    <= avg_c;
                        down_q   <= down_c;
                        wr_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (last_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty_c) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pixel_scaler.sv
// Scoreboard bench for pixel_scaler on a 4x2 source with SHIFT=1, ROM latency 1 and 3.
`timescale 1ns/1ps
module tb_pixel_scaler;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RD_ADDR_W = 15;
    localparam int unsigned WR_ADDR_W = 17;

    typedef struct {
        int unsigned cyc;
        int unsigned addr;
        int unsigned data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       sel = 1'b0;
    logic       mon_on = 1'b0;
    logic [1:0] mode = 2'd0;

    logic                 rd_en1, wr_en1, busy1, done1;
    logic [RD_ADDR_W-1:0] rd_addr1;
    logic [WR_ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0]    rd_data1, wr_data1;
    logic                 rd_en3, wr_en3, busy3, done3;
    logic [RD_ADDR_W-1:0] rd_addr3;
    logic [WR_ADDR_W-1:0] wr_addr3;
    logic [DATA_W-1:0]    rd_data3, wr_data3;

    pixel_scaler #(.DATA_W(8), .IN_W(4), .IN_H(2), .SHIFT(1), .ROM_LAT(1),
                   .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1));

    pixel_scaler #(.DATA_W(8), .IN_W(4), .IN_H(2), .SHIFT(1), .ROM_LAT(3),
                   .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .busy(busy3), .done(done3));

    // Synchronous ROM models with 1 and 3 cycles of latency
    logic [DATA_W-1:0] rom [0:7];
    logic [DATA_W-1:0] p1;
    logic [DATA_W-1:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= rom[rd_addr1[2:0]];
        p3[0] <= rom[rd_addr3[2:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd_data1 = p1;
    assign rd_data3 = p3[2];

    logic                 m_rd_en, m_wr_en, m_busy, m_done;
    logic [RD_ADDR_W-1:0] m_rd_addr;
    logic [WR_ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0]    m_wr_data;
    assign m_rd_en   = sel ? rd_en3   : rd_en1;
    assign m_rd_addr = sel ? rd_addr3 : rd_addr1;
    assign m_wr_en   = sel ? wr_en3   : wr_en1;
    assign m_wr_addr = sel ? wr_addr3 : wr_addr1;
    assign m_wr_data = sel ? wr_data3 : wr_data1;
    assign m_busy    = sel ? busy3    : busy1;
    assign m_done    = sel ? done3    : done1;

    int unsigned cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    ev_t         rq[$];
    ev_t         wq[$];
    int unsigned dq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          done_seen = 0;
    int          first_rd = -1;
    int          first_wr = -1;
    int unsigned cap [0:31];
    ev_t         e;
    int unsigned dc;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    task automatic fail_now(input string msg);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, cnt);
    endtask

    // Monitor: pop the scoreboard whenever the selected DUT presents a read, write or done
    always @(negedge clk) begin
        if (mon_on) begin
            if (m_rd_en) begin
                if (first_rd < 0) first_rd = int'(cnt);
                if (rq.size() == 0) begin
                    fail_now($sformatf("unexpected_read addr %0d", m_rd_addr));
                end else begin
                    e = rq.pop_front();
                    check("rd_addr", m_rd_addr, e.addr);
                    check("rd_cycle", cnt, e.cyc);
                end
            end
            if (m_wr_en) begin
                wr_seen++;
                if (first_wr < 0) first_wr = int'(cnt);
                if (m_wr_addr < 32) cap[m_wr_addr] = m_wr_data;
                if (wq.size() == 0) begin
                    fail_now($sformatf("unexpected_write addr %0d data %0d", m_wr_addr, m_wr_data));
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", m_wr_addr, e.addr);
                    check("wr_data", m_wr_data, e.data);
                    check("wr_cycle", cnt, e.cyc);
                end
            end
            if (m_done) begin
                done_seen++;
                check("busy_at_done", m_busy, 0);
                if (dq.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    dc = dq.pop_front();
                    check("done_cycle", cnt, dc);
                end
            end
        end
    end

    function automatic void push_rd(input int unsigned t0, input int unsigned c, input int unsigned a);
        ev_t x;
        x.cyc = t0 + c; x.addr = a; x.data = 0;
        rq.push_back(x);
    endfunction

    function automatic void push_wr(input int unsigned t0, input int unsigned c,
                                    input int unsigned a, input int unsigned d);
        ev_t x;
        x.cyc = t0 + c; x.addr = a; x.data = d;
        wq.push_back(x);
    endfunction

    // 8x4 replicated frame: output (oy,ox) reads source (oy/2, ox/2); rom[a] = a
    function automatic void push_rep(input int unsigned t0, input int unsigned lat,
                                     input int unsigned n_rd, input int unsigned n_wr, input bit with_done);
        for (int unsigned k = 0; k < 32; k++) begin
            int unsigned a;
            a = ((k / 8) / 2) * 4 + (k % 8) / 2;
            if (k < n_rd) push_rd(t0, k + 1, a);
            if (k < n_wr) push_wr(t0, k + lat + 2, k, a);
        end
        if (with_done) dq.push_back(t0 + 32 + lat + 2);
    endfunction

    task automatic launch(input logic [1:0] m, input bit use3, output int unsigned t0);
        @(posedge clk); #1;
        mode = m;
        sel  = use3;
        wr_seen = 0; done_seen = 0; first_rd = -1; first_wr = -1;
        for (int i = 0; i < 32; i++) cap[i] = 32'hFFFF;
        if (use3) start3 = 1'b1; else start = 1'b1;
        t0 = cnt;
        @(posedge clk); #1;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = (m == 2'd2) ? 2'd0 : 2'd2;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        while ((rq.size() + wq.size() + dq.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if ((rq.size() + wq.size() + dq.size()) != 0) begin
            fail_now($sformatf("timeout with %0d reads %0d writes %0d dones pending",
                               rq.size(), wq.size(), dq.size()));
            rq.delete(); wq.delete(); dq.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"},   rd_en1, 0);
        check({tag, "_rd_addr"}, rd_addr1, 0);
        check({tag, "_wr_en"},   wr_en1, 0);
        check({tag, "_wr_addr"}, wr_addr1, 0);
        check({tag, "_wr_data"}, wr_data1, 0);
        check({tag, "_busy"},    busy1, 0);
        check({tag, "_done"},    done1, 0);
    endtask

    int unsigned avg_rd [8] = '{0, 1, 4, 5, 2, 3, 6, 7};

    initial begin
        int unsigned t0;
        for (int i = 0; i < 8; i++) rom[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_on = 1'b1;

        // Replicate, ROM latency 1
        launch(2'd0, 1'b0, t0);
        push_rep(t0, 1, 32, 32, 1'b1);
        wait_idle(200);
        check("rep_wr11_data", cap[11], 1);
        check("rep_wr21_data", cap[21], 6);
        check("rep_write_count", wr_seen, 32);

        // Decimate
        launch(2'd1, 1'b0, t0);
        push_rd(t0, 1, 0);
        push_rd(t0, 2, 2);
        push_wr(t0, 3, 0, 0);
        push_wr(t0, 4, 1, 2);
        dq.push_back(t0 + 5);
        wait_idle(100);

        // Block average
        launch(2'd2, 1'b0, t0);
        for (int unsigned i = 0; i < 8; i++) push_rd(t0, i + 1, avg_rd[i]);
        push_wr(t0, 6, 0, 2);
        push_wr(t0, 10, 1, 4);
        dq.push_back(t0 + 11);
        wait_idle(100);

        // Block average of full-scale pixels
        for (int i = 0; i < 8; i++) rom[i] = 8'd255;
        launch(2'd2, 1'b0, t0);
        for (int unsigned i = 0; i < 8; i++) push_rd(t0, i + 1, avg_rd[i]);
        push_wr(t0, 6, 0, 255);
        push_wr(t0, 10, 1, 255);
        dq.push_back(t0 + 11);
        wait_idle(100);
        for (int i = 0; i < 8; i++) rom[i] = 8'(i);

        // Replicate, ROM latency 3
        launch(2'd0, 1'b1, t0);
        push_rep(t0, 3, 32, 32, 1'b1);
        wait_idle(200);
        check("lat3_rd_to_wr", longint'(first_wr - first_rd), 4);
        sel = 1'b0;

        // Second start while busy is ignored
        launch(2'd0, 1'b0, t0);
        push_rep(t0, 1, 32, 32, 1'b1);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(200);
        check("restart_write_count", wr_seen, 32);
        check("restart_done_count", done_seen, 1);

        // Reset in cycle 12 aborts the frame
        launch(2'd0, 1'b0, t0);
        push_rep(t0, 1, 12, 10, 1'b0);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        repeat (10) @(posedge clk);
        check("abort_write_count", wr_seen, 10);
        check("abort_pending", rq.size() + wq.size() + dq.size(), 0);

        // Clean frame after the abort
        launch(2'd0, 1'b0, t0);
        push_rep(t0, 1, 32, 32, 1'b1);
        wait_idle(200);
        check("post_abort_write_count", wr_seen, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_scaler.md
# pixel_scaler

Parametrised integer image scaler that replaces the fixed ×2 pixel replicator in the video path. It reads a source frame from a synchronous ROM/RAM and writes a scaled frame into the VGA frame buffer RAM. It supports three run-time modes: replicate (zoom-in), decimate (zoom-out) and block-average (zoom-out). The block sits between the image ROM and the VGA frame-buffer write port and is launched once per frame by the top-level controller through a start/busy/done handshake.

## Interface
- DATA_W, 8, pixel width in bits
- IN_W, 160, source width in pixels
- IN_H, 120, source height in pixels
- SHIFT, 1, log2 of scale factor; F = 2^SHIFT, 1..3
- ROM_LAT, 1, source-memory read latency in cycles, 1..4
- RD_ADDR_W, 15, source address width; must hold IN_W*IN_H-1
- WR_ADDR_W, 17, frame-buffer address width; must hold (IN_W*F)*(IN_H*F)-1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle launch pulse; honoured only when idle
- mode  in  2  0 replicate, 1 decimate, 2 average, 3 treated as 0; sampled on accepted start
- rd_en  out  1  source read strobe
- rd_addr  out  RD_ADDR_W  source address, valid with rd_en
- rd_data  in  DATA_W  source pixel, valid ROM_LAT cycles after rd_en
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  WR_ADDR_W  frame-buffer address
- wr_data  out  DATA_W  frame-buffer pixel
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the last write has been issued

## Operation
- Output geometry: replicate OW=IN_W<<SHIFT, OH=IN_H<<SHIFT; decimate/average OW=IN_W>>SHIFT, OH=IN_H>>SHIFT. IN_W and IN_H are multiples of F.
- Output pixels are produced in raster order (oy outer, ox inner). wr_addr = oy*OW+ox, incrementing by 1 per write from 0 to OW*OH-1.
- Replicate: one read per output pixel, rd_addr = (oy>>SHIFT)*IN_W + (ox>>SHIFT). wr_data = rd_data.
- Decimate: one read per output pixel, rd_addr = (oy<<SHIFT)*IN_W + (ox<<SHIFT). wr_data = rd_data.
- Average: F*F reads per output pixel, sub-index di outer, dj inner, rd_addr = ((oy<<SHIFT)+di)*IN_W + (ox<<SHIFT)+dj.
  - Accumulator is DATA_W+2*SHIFT bits and is cleared on the first sub-read.
  - wr_data = accumulator >> (2*SHIFT), truncated with no rounding.
  - Exactly one write per output pixel, issued after the last sub-read's data returns.
- Address arithmetic is unsigned and computed at full width with no wrap.
- FSM states:
  - IDLE: on start, latch mode and go to RUN.
  - RUN: one rd_en per cycle. After the last read, go to DRAIN.
  - DRAIN: wait until the read/write pipeline is empty, then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- start during RUN, DRAIN or DONE is ignored; mode changes while busy have no effect.
- Reset (any state, including mid-frame) takes effect at the next edge:
  - FSM returns to IDLE and all counters and the pipeline are cleared.
  - All outputs go to 0: rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done.
  - No write from the aborted frame appears after reset.

## Timing
- Start accepted at edge of cycle 0. busy and the first rd_en are asserted in cycle 1.
- A read issued in cycle t produces its write (replicate/decimate) in cycle t+ROM_LAT+1. wr_addr and wr_data are registered and valid together with wr_en.
- Average: the write for a pixel is in cycle t_last+ROM_LAT+1, where t_last is the cycle of its final sub-read. Reads remain back-to-back across pixel boundaries.
- Total reads R = OW*OH (replicate/decimate) or OW*OH*F*F (average). The last rd_en is in cycle R.
- The last wr_en is in cycle R+ROM_LAT+1. done is in cycle R+ROM_LAT+2, and busy drops in that same cycle.
- Throughput: one read per cycle with no bubbles. Writes are one per cycle (replicate/decimate) or one per F*F cycles (average).

## Test plan
All scenarios use IN_W=4, IN_H=2, SHIFT=1, with the ROM preloaded as rom[a]=a.

- Replicate, ROM_LAT=1 → exactly 32 writes with wr_addr 0..31 in order.
  - wr_addr 11 carries data 1; wr_addr 21 carries data 6.
  - Last wr_en in cycle 34, done in cycle 35.
- Decimate → 2 writes: (0,0) and (1,2). done in cycle 5.
- Average → rd_addr sequence 0,1,4,5,2,3,6,7. Writes are (0,2) in cycle 6 and (1,4) in cycle 10.
- Average with rom[a]=255 for all a → wr_data 255, confirming no accumulator overflow.
- ROM_LAT=3, replicate → first wr_en exactly 4 cycles after first rd_en; done in cycle 37.
- start pulsed again in cycle 10 → ignored, still 32 writes and one done.
  - rst asserted in cycle 12 → all outputs 0 in cycle 13, with no wr_en until the next start.
  - A new start then produces a clean 32-write frame.
